mips32_trace_capture: RTL and testbench

Retirement trace capture for the mips32 pipeline. Samples register write-backs and data-memory stores from the CPU's debug port every cycle. Timestamps them and buffers them in a small FIFO. Drains them one record at a time over a valid/ready stream to a trace consumer (bench monitor, UART dumper, logic analyser). It is the consuming end of the CPU debug signals `brAddr/brDataIn/memAddr/memDataIn`. It replaces free-running `$display` polling with lossless, ordered records plus explicit overflow reporting.

---
 rtl/mips32_trace_pkg.sv | 38 +++
 rtl/trace_fifo_2w1r.sv | 56 +++++
 rtl/mips32_trace_capture.sv | 122 ++++++++++++
 tb/tb_mips32_trace_capture.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips32_trace_pkg.sv
// Trace record layout, kind codes and a saturating counter helper shared by the capture block and its consumers.
// Pure definitions: no latency, no flow control.
package mips32_trace_pkg;

  localparam int KIND_W      = 2;
  localparam int REG_W       = 5;
  localparam int ADDR_W      = 14;
  localparam int DATA_W      = 32;
  localparam int DROP_W      = 16;
  localparam int DEF_STAMP_W = 16;

  // Field offsets inside traceData; the kind field sits above the stamp, so its offset depends on STAMP_W.
  localparam int DATA_LSB  = 0;
  localparam int ADDR_LSB  = DATA_LSB + DATA_W;
  localparam int STAMP_LSB = ADDR_LSB + ADDR_W;

  typedef enum logic [KIND_W-1:0] {
    KIND_REG  = 2'b00,
    KIND_MEM  = 2'b01,
    KIND_OVF  = 2'b10,
    KIND_RSVD = 2'b11
  } trace_kind_t;

  // Record as seen on traceData with the default 16-bit stamp.
  typedef struct packed {
    trace_kind_t             kind;
    logic [DEF_STAMP_W-1:0]  stamp;
    logic [ADDR_W-1:0]       addr;
    logic [DATA_W-1:0]       data;
  } trace_rec_t;

  function automatic logic [DROP_W-1:0] sat_add_drop(input logic [DROP_W-1:0] a, input logic [1:0] b);
    logic [DROP_W:0] sum;
    sum = {1'b0, a} + {{(DROP_W-1){1'b0}}, b};
    return sum[DROP_W] ? {DROP_W{1'b1}} : sum[DROP_W-1:0];
  endfunction

endpackage

// File: rtl/trace_fifo_2w1r.sv
// DEPTH-entry FIFO, two write ports (wr1 lands after wr0), one read port; reports occupancy at cycle start.
// Head visible the cycle after it is written; writer must respect occupancy, a same-cycle pop frees nothing.
module trace_fifo_2w1r #(
  parameter int DEPTH = 16,
  parameter int W     = 64,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr0_vld,
  input  logic [W-1:0]     wr0_dat,
  input  logic             wr1_vld,
  input  logic [W-1:0]     wr1_dat,
  output logic             rd_vld,
  input  logic             rd_rdy,
  output logic [W-1:0]     rd_dat,
  output logic [CNT_W-1:0] occ
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pop;

  assign rd_vld = (cnt_q != '0);
  assign rd_dat = rd_vld ? mem_q[rptr_q] : '0;
  assign occ    = cnt_q;
  assign pop    = rd_vld && rd_rdy;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q + PTR_W'(wr0_vld) + PTR_W'(wr1_vld);
    rptr_d = rptr_q + PTR_W'(pop);
    cnt_d  = cnt_q + CNT_W'(wr0_vld) + CNT_W'(wr1_vld) - CNT_W'(pop);
    if (wr0_vld) mem_d[wptr_q] = wr0_dat;
    if (wr1_vld) mem_d[wptr_q + PTR_W'(wr0_vld)] = wr1_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q  <= '{default: '0};
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/mips32_trace_capture.sv
// Stamps WB/store events, admits up to 2 per cycle (marker > REG > MEM) into a FIFO; records drain 1/cycle over traceValid/traceReady.
// Record visible the cycle after sampling; a stalled consumer never stalls sampling, excess events become drops + an OVF marker. MEM capture only with MIPS32_TRACE_MEM_EN.
module mips32_trace_capture
  import mips32_trace_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int STAMP_W = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  traceEn,
  input  logic                                  wbValid,
  input  logic [4:0]                            brAddr,
  input  logic [31:0]                           brDataIn,
  input  logic                                  memWrite,
  input  logic [13:0]                           memAddr,
  input  logic [31:0]                           memDataIn,
  output logic                                  traceValid,
  input  logic                                  traceReady,
  output logic [KIND_W+STAMP_W+ADDR_W+DATA_W-1:0] traceData,
  output logic [15:0]                           dropCount
);

  localparam int REC_W = KIND_W + STAMP_W + ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [STAMP_W-1:0] stamp_q, stamp_d;
  logic [DROP_W-1:0]  pend_drop_q, pend_drop_d;
  logic [DROP_W-1:0]  drop_count_q, drop_count_d;

  logic [CNT_W-1:0]   occ;
  logic [CNT_W-1:0]   free;
  logic [1:0]         cap;
  logic [1:0]         n_push;
  logic [1:0]         n_drop;
  logic               ovf_push;
  logic               wr0_vld, wr1_vld;
  logic [REC_W-1:0]   wr0_dat, wr1_dat;

  // Candidates in priority order: 0 = overflow marker, 1 = REG, 2 = MEM.
  logic [2:0]         cand_vld;
  logic [REC_W-1:0]   cand_dat [3];

  assign cand_vld[0] = (pend_drop_q != '0);
  assign cand_vld[1] = traceEn && wbValid;
  assign cand_dat[0] = {KIND_OVF, stamp_q, {ADDR_W{1'b0}}, {(DATA_W-DROP_W){1'b0}}, pend_drop_q};
  assign cand_dat[1] = {KIND_REG, stamp_q, {(ADDR_W-REG_W){1'b0}}, brAddr, brDataIn};

`ifdef MIPS32_TRACE_MEM_EN
  assign cand_vld[2] = traceEn && memWrite;
  assign cand_dat[2] = {KIND_MEM, stamp_q, memAddr, memDataIn};
`else
  logic mem_unused;
  assign mem_unused  = ^{memWrite, memAddr, memDataIn};
  assign cand_vld[2] = 1'b0;
  assign cand_dat[2] = '0;
`endif

  always_comb begin
    free     = CNT_W'(DEPTH) - occ;
    cap      = (free >= CNT_W'(2)) ? 2'd2 : free[1:0];
    n_push   = 2'd0;
    n_drop   = 2'd0;
    ovf_push = 1'b0;
    wr0_vld  = 1'b0;
    wr1_vld  = 1'b0;
    wr0_dat  = '0;
    wr1_dat  = '0;
    for (int i = 0; i < 3; i++) begin
      if (cand_vld[i]) begin
        if (n_push < cap) begin
          if (n_push == 2'd0) begin
            wr0_vld = 1'b1;
            wr0_dat = cand_dat[i];
          end else begin
            wr1_vld = 1'b1;
            wr1_dat = cand_dat[i];
          end
          n_push = n_push + 2'd1;
          if (i == 0) ovf_push = 1'b1;
        end else if (i != 0) begin
          // A blocked marker simply stays pending; only real events count as lost.
          n_drop = n_drop + 2'd1;
        end
      end
    end
    stamp_d      = stamp_q + 1'b1;
    pend_drop_d  = ovf_push ? {{(DROP_W-2){1'b0}}, n_drop} : sat_add_drop(pend_drop_q, n_drop);
    drop_count_d = sat_add_drop(drop_count_q, n_drop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stamp_q      <= '0;
      pend_drop_q  <= '0;
      drop_count_q <= '0;
    end else begin
      stamp_q      <= stamp_d;
      pend_drop_q  <= pend_drop_d;
      drop_count_q <= drop_count_d;
    end
  end

  trace_fifo_2w1r #(
    .DEPTH (DEPTH),
    .W     (REC_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr0_vld (wr0_vld),
    .wr0_dat (wr0_dat),
    .wr1_vld (wr1_vld),
    .wr1_dat (wr1_dat),
    .rd_vld  (traceValid),
    .rd_rdy  (traceReady),
    .rd_dat  (traceData),
    .occ     (occ)
  );

  assign dropCount = drop_count_q;

endmodule

// File: tb/tb_mips32_trace_capture.sv
// Directed bench for mips32_trace_capture: reset, single/dual events, backpressure, full-with-pop, overflow, async reset.
`timescale 1ns/1ps
module tb_mips32_trace_capture;
  import mips32_trace_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        traceEn = 1'b0;
  logic        wbValid = 1'b0;
  logic [4:0]  brAddr = '0;
  logic [31:0] brDataIn = '0;
  logic        memWrite = 1'b0;
  logic [13:0] memAddr = '0;
  logic [31:0] memDataIn = '0;
  logic        traceValid;
  logic        traceReady = 1'b0;
  logic [63:0] traceData;
  logic [15:0] dropCount;

  int          errors = 0;
  int          checks = 0;
  int unsigned stamp_m = 0;

  always #5 clk = ~clk;

  mips32_trace_capture #(.DEPTH(16), .STAMP_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .traceEn    (traceEn),
    .wbValid    (wbValid),
    .brAddr     (brAddr),
    .brDataIn   (brDataIn),
    .memWrite   (memWrite),
    .memAddr    (memAddr),
    .memDataIn  (memDataIn),
    .traceValid (traceValid),
    .traceReady (traceReady),
    .traceData  (traceData),
    .dropCount  (dropCount)
  );

  function automatic logic [63:0] mk(trace_kind_t k, int unsigned s, int unsigned a, logic [31:0] d);
    trace_rec_t r;
    r.kind  = k;
    r.stamp = 16'(s);
    r.addr  = 14'(a);
    r.data  = d;
    return r;
  endfunction

  // One clock: inputs captured at posedge, outputs observed at the following negedge.
  task automatic tick();
    @(posedge clk);
    if (!rst) stamp_m++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    traceEn = 0; wbValid = 0; memWrite = 0; traceReady = 0;
    rst = 1;
    tick();
    tick();
    rst = 0;
    stamp_m = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    tick();
    checks++; if (traceValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", traceValid); end
    checks++; if (traceData !== 64'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", traceData); end
    checks++; if (dropCount !== 16'h0) begin errors++; $display("FAIL reset_drop: got %0d expected 0", dropCount); end
    rst = 0;
    stamp_m = 0;
    tick();
    checks++; if (traceValid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b expected 0", traceValid); end
  endtask

  task automatic test_single();
    logic [63:0] exp_rec;
    do_reset();
    repeat (5) tick();
    traceReady = 1; traceEn = 1; wbValid = 1; brAddr = 5'd8; brDataIn = 32'h1234;
    exp_rec = mk(KIND_REG, 5, 8, 32'h1234);
    tick();
    wbValid = 0;
    checks++; if (traceValid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", traceValid); end
    checks++; if (traceData !== exp_rec) begin errors++; $display("FAIL single_data: got %h expected %h", traceData, exp_rec); end
    tick();
    checks++; if (traceValid !== 1'b0) begin errors++; $display("FAIL single_one_cycle: got %b expected 0", traceValid); end
  endtask

`ifdef MIPS32_TRACE_MEM_EN
  task automatic test_dual();
    logic [63:0] exp_reg, exp_mem;
    do_reset();
    repeat (3) tick();
    traceReady = 1; traceEn = 1;
    wbValid = 1; brAddr = 5'd3; brDataIn = 32'hAA;
    memWrite = 1; memAddr = 14'h0040; memDataIn = 32'd7;
    exp_reg = mk(KIND_REG, 3, 3, 32'hAA);
    exp_mem = mk(KIND_MEM, 3, 14'h0040, 32'd7);
    tick();
    wbValid = 0; memWrite = 0;
    checks++; if (traceData !== exp_reg || traceValid !== 1'b1) begin errors++; $display("FAIL dual_reg: got %b/%h expected 1/%h", traceValid, traceData, exp_reg); end
    tick();
    checks++; if (traceData !== exp_mem || traceValid !== 1'b1) begin errors++; $display("FAIL dual_mem: got %b/%h expected 1/%h", traceValid, traceData, exp_mem); end
    tick();
    checks++; if (traceValid !== 1'b0) begin errors++; $display("FAIL dual_empty: got %b expected 0", traceValid); end
  endtask
`else
  task automatic test_macro_off();
    do_reset();
    traceReady = 1; traceEn = 1;
    for (int i = 0; i < 8; i++) begin
      memWrite = (i % 2 == 0); memAddr = 14'(i + 1); memDataIn = 32'(i * 5);
      tick();
      checks++; if (traceValid !== 1'b0) begin errors++; $display("FAIL macro_off_valid: got %b expected 0 at step %0d", traceValid, i); end
    end
    memWrite = 0;
    checks++; if (dropCount !== 16'h0) begin errors++; $display("FAIL macro_off_drop: got %0d expected 0", dropCount); end
  endtask
`endif

  task automatic test_backpressure();
    logic [63:0] exp_q[$];
    int n_got = 0;
    do_reset();
    traceEn = 1;
    for (int c = 0; c < 60; c++) begin
      traceReady = (c % 2 == 1);
      if (c < 16) begin
        wbValid = 1; brAddr = 5'(c); brDataIn = 32'(c * 3 + 7);
        exp_q.push_back(mk(KIND_REG, stamp_m, c, 32'(c * 3 + 7)));
      end else wbValid = 0;
      if (traceValid) begin
        checks++;
        if (n_got >= exp_q.size()) begin errors++; $display("FAIL bp_extra: got %h expected no record", traceData); end
        else if (traceData !== exp_q[n_got]) begin errors++; $display("FAIL bp_data[%0d]: got %h expected %h", n_got, traceData, exp_q[n_got]); end
        if (traceReady) n_got++;
      end
      tick();
    end
    checks++; if (n_got != 16) begin errors++; $display("FAIL bp_count: got %0d expected 16", n_got); end
    checks++; if (dropCount !== 16'h0) begin errors++; $display("FAIL bp_drop: got %0d expected 0", dropCount); end
  endtask

  task automatic test_full_pop();
    logic [63:0] exp_q[$];
    int n_got = 0;
    do_reset();
    traceEn = 1; traceReady = 0;
    for (int i = 0; i < 16; i++) begin
      wbValid = 1; brAddr = 5'(i); brDataIn = 32'(32'h500 + i);
      exp_q.push_back(mk(KIND_REG, stamp_m, i, 32'(32'h500 + i)));
      tick();
    end
    for (int c = 0; c < 24; c++) begin
      traceReady = 1;
      if (c == 0) begin wbValid = 1; brAddr = 5'd31; brDataIn = 32'hDEAD; end
      else wbValid = 0;
      if (c == 1) exp_q.push_back(mk(KIND_OVF, stamp_m, 0, 32'd1));
      if (traceValid) begin
        checks++;
        if (n_got >= exp_q.size()) begin errors++; $display("FAIL fp_extra: got %h expected no record", traceData); end
        else if (traceData !== exp_q[n_got]) begin errors++; $display("FAIL fp_data[%0d]: got %h expected %h", n_got, traceData, exp_q[n_got]); end
        n_got++;
      end
      tick();
      if (c == 0) begin
        checks++; if (dropCount !== 16'd1) begin errors++; $display("FAIL fp_drop: got %0d expected 1", dropCount); end
      end
    end
    checks++; if (n_got != 17) begin errors++; $display("FAIL fp_count: got %0d expected 17", n_got); end
  endtask

  task automatic test_overflow();
    logic [63:0] exp_q[$];
    int n_got = 0;
    do_reset();
    traceEn = 1; traceReady = 0;
    for (int i = 0; i < 20; i++) begin
      wbValid = 1; brAddr = 5'(i); brDataIn = 32'(32'hC000 + i);
      if (i < 16) exp_q.push_back(mk(KIND_REG, stamp_m, i, 32'(32'hC000 + i)));
      tick();
    end
    wbValid = 0;
    checks++; if (traceValid !== 1'b1) begin errors++; $display("FAIL ovf_held: got %b expected 1", traceValid); end
    checks++; if (dropCount !== 16'd4) begin errors++; $display("FAIL ovf_drop: got %0d expected 4", dropCount); end
    for (int c = 0; c < 26; c++) begin
      traceReady = 1;
      if (c == 1) exp_q.push_back(mk(KIND_OVF, stamp_m, 0, 32'd4));
      if (c == 2) begin
        wbValid = 1; brAddr = 5'd20; brDataIn = 32'hBEEF;
        exp_q.push_back(mk(KIND_REG, stamp_m, 20, 32'hBEEF));
      end else wbValid = 0;
      if (traceValid) begin
        checks++;
        if (n_got >= exp_q.size()) begin errors++; $display("FAIL ovf_extra: got %h expected no record", traceData); end
        else if (traceData !== exp_q[n_got]) begin errors++; $display("FAIL ovf_data[%0d]: got %h expected %h", n_got, traceData, exp_q[n_got]); end
        n_got++;
      end
      tick();
    end
    checks++; if (n_got != 18) begin errors++; $display("FAIL ovf_count: got %0d expected 18", n_got); end
    checks++; if (dropCount !== 16'd4) begin errors++; $display("FAIL ovf_drop_kept: got %0d expected 4", dropCount); end
  endtask

  // Runs straight after test_overflow, so dropCount is still 4 going in.
  task automatic test_reset_mid();
    logic [63:0] exp_rec;
    traceEn = 1; traceReady = 0;
    for (int i = 0; i < 6; i++) begin
      wbValid = 1; brAddr = 5'(i); brDataIn = 32'(i);
      tick();
    end
    wbValid = 0;
    checks++; if (traceValid !== 1'b1 || dropCount !== 16'd4) begin errors++; $display("FAIL rm_pre: got %b/%0d expected 1/4", traceValid, dropCount); end
    #2 rst = 1;
    #1;
    checks++; if (traceValid !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b expected 0", traceValid); end
    checks++; if (dropCount !== 16'h0) begin errors++; $display("FAIL rm_drop: got %0d expected 0", dropCount); end
    checks++; if (traceData !== 64'h0) begin errors++; $display("FAIL rm_data: got %h expected 0", traceData); end
    tick();
    rst = 0;
    stamp_m = 0;
    traceReady = 1; wbValid = 1; brAddr = 5'd9; brDataIn = 32'd99;
    exp_rec = mk(KIND_REG, 0, 9, 32'd99);
    tick();
    wbValid = 0;
    checks++; if (traceValid !== 1'b1 || traceData !== exp_rec) begin errors++; $display("FAIL rm_first: got %b/%h expected 1/%h", traceValid, traceData, exp_rec); end
    tick();
    checks++; if (traceValid !== 1'b0) begin errors++; $display("FAIL rm_empty: got %b expected 0", traceValid); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
`ifdef MIPS32_TRACE_MEM_EN
    test_dual();
`else
    test_macro_off();
`endif
    test_backpressure();
    test_full_pop();
    test_overflow();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
